// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: arms/restarts the UART receiver, buffers bytes in a small FIFO,
// and counts framing errors when UART_RX_CTRL_ERRCNT_EN is defined (otherwise err_cnt is 0).
module uart_rx_ctrl #(
  parameter int DEPTH   = 4,
  parameter int RST_CYC = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rx_rdc,
  input  logic       rx_error,
  input  logic [7:0] rx_data,
  output logic       rx_ce,
  output logic       rx_rd,
  output logic       rx_rst_n,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       fifo_full,
  output logic [7:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, ARM, WAIT, CAPTURE, RECOVER} state_t;

  state_t        state_reg, state_next;
  logic [4:0]    arm_cnt_reg;
  logic [7:0]    mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          push, pop;

  assign push      = (state_reg == CAPTURE);
  assign pop       = m_valid && m_ready;
  assign m_valid   = (count_reg != '0);
  assign fifo_full = (count_reg == CW'(DEPTH));
  assign m_data    = mem_reg[rd_ptr_reg];

  // Receiver controls decode straight from the state register.
  assign rx_ce    = (state_reg == WAIT);
  assign rx_rd    = (state_reg == WAIT);
  assign rx_rst_n = (state_reg != ARM);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable && !fifo_full) state_next = ARM;
      ARM:     if (arm_cnt_reg == 5'd0) state_next = WAIT;
      WAIT: begin
        // A framing error wins over a simultaneous frame-complete; that byte is dropped.
        if (rx_error)     state_next = RECOVER;
        else if (rx_rdc)  state_next = CAPTURE;
        else if (!enable) state_next = IDLE;
      end
      CAPTURE: state_next = (enable && count_next != CW'(DEPTH)) ? ARM : IDLE;
      RECOVER: state_next = enable ? ARM : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      arm_cnt_reg <= 5'(RST_CYC - 1);
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      // Counter idles preloaded so ARM always lasts exactly RST_CYC cycles.
      arm_cnt_reg <= (state_reg == ARM) ? arm_cnt_reg - 5'd1 : 5'(RST_CYC - 1);
      count_reg   <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= rx_data;
  end

`ifdef UART_RX_CTRL_ERRCNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_reg <= 8'd0;
    end else if (state_reg == RECOVER && err_cnt_reg != 8'hFF) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (DEPTH=4, RST_CYC=24); expected err_cnt
// follows whether UART_RX_CTRL_ERRCNT_EN is defined for the build.
module tb_uart_rx_ctrl;

  localparam int DEPTH   = 4;
  localparam int RST_CYC = 24;
`ifdef UART_RX_CTRL_ERRCNT_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, enable, rx_rdc, rx_error, m_ready;
  logic [7:0] rx_data;
  logic       rx_ce, rx_rd, rx_rst_n, m_valid, fifo_full;
  logic [7:0] m_data, err_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_rx_ctrl #(.DEPTH(DEPTH), .RST_CYC(RST_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rx_rdc    (rx_rdc),
    .rx_error  (rx_error),
    .rx_data   (rx_data),
    .rx_ce     (rx_ce),
    .rx_rd     (rx_rd),
    .rx_rst_n  (rx_rst_n),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .fifo_full (fifo_full),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_err(input int e);
    if (!ERR_ON) return 8'd0;
    return (e > 255) ? 8'hFF : 8'(e);
  endfunction

  // Counts consecutive samples with rx_rst_n low, starting with the current one.
  task automatic count_arm(output int n, output logic ce_seen);
    n = 0;
    ce_seen = 1'b0;
    while (rx_rst_n == 1'b0 && n < 200) begin
      ce_seen = ce_seen | rx_ce | rx_rd;
      n++;
      tick();
    end
  endtask

  task automatic wait_wait();
    int n;
    n = 0;
    while (rx_ce == 1'b0 && n < 200) begin
      n++;
      tick();
    end
    check("wait_rx_ce", rx_ce, 1);
  endtask

  // Presents one good frame while in WAIT; returns one cycle after CAPTURE.
  task automatic deliver(input logic [7:0] d);
    rx_data = d;
    rx_rdc  = 1'b1;
    tick();
    tick();
    rx_rdc  = 1'b0;
    $display("[TB] byte %02h delivered", d);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   errs;
    logic ce_seen;
    logic [7:0] exp_b;

    rst = 1'b0; enable = 1'b0; rx_rdc = 1'b0; rx_error = 1'b0; rx_data = 8'h00; m_ready = 1'b0;
    tick();
    tick();
    check("rst_ce", rx_ce, 0);
    check("rst_rd", rx_rd, 0);
    check("rst_rst_n", rx_rst_n, 1);
    check("rst_valid", m_valid, 0);
    check("rst_full", fifo_full, 0);
    check("rst_err", err_cnt, 0);

    rst = 1'b1;
    tick();
    check("idle_rst_n", rx_rst_n, 1);

    // Arm: reset pulse length and receiver enabled afterwards
    enable = 1'b1;
    tick();
    count_arm(n, ce_seen);
    $display("[TB] arm pulse %0d cycles", n);
    check("arm_len", n, RST_CYC);
    check("arm_ce_low", ce_seen, 0);
    check("wait_ce", rx_ce, 1);
    check("wait_rd", rx_rd, 1);

    // Single byte capture and pop
    rx_data = 8'hA5; rx_rdc = 1'b1;
    tick();
    check("cap_valid_early", m_valid, 0);
    check("cap_ce", rx_ce, 0);
    tick();
    check("push_valid", m_valid, 1);
    check("push_data", m_data, 8'hA5);
    check("rearm_rst_n", rx_rst_n, 0);
    rx_rdc = 1'b0;
    m_ready = 1'b1;
    count_arm(n, ce_seen);
    m_ready = 1'b0;
    check("rearm_len", n, RST_CYC);
    check("pop_empty", m_valid, 0);

    // Fill to full, stall in IDLE, then drain with pointer wrap
    for (int i = 1; i <= 4; i++) begin
      deliver(8'(i));
      if (i < 4) wait_wait();
    end
    check("full_flag", fifo_full, 1);
    check("full_ce", rx_ce, 0);
    check("full_rst_n", rx_rst_n, 1);
    check("full_head", m_data, 8'h01);
    tick(); tick(); tick();
    check("full_idle_hold", rx_rst_n, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    $display("[TB] popped 01");
    check("pop1_full", fifo_full, 0);
    tick();
    check("space_arm", rx_rst_n, 0);
    wait_wait();
    m_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      exp_b = 8'(i);
      check("drain_data", m_data, exp_b);
      $display("[TB] popped %02h", m_data);
      tick();
    end
    m_ready = 1'b0;
    check("drain_empty", m_valid, 0);

    // Framing error with simultaneous rdc, then saturation
    rx_data = 8'hFF; rx_error = 1'b1; rx_rdc = 1'b1;
    tick();
    check("rec_ce", rx_ce, 0);
    tick();
    rx_error = 1'b0; rx_rdc = 1'b0;
    errs = 1;
    $display("[TB] framing error %0d injected", errs);
    check("err_no_push", m_valid, 0);
    check("err_cnt1", err_cnt, exp_err(errs));
    check("err_rearm", rx_rst_n, 0);
    wait_wait();
    while (errs < 260) begin
      rx_error = 1'b1;
      tick();
      tick();
      rx_error = 1'b0;
      errs++;
      $display("[TB] framing error %0d injected", errs);
      if (errs == 255) check("err_cnt255", err_cnt, exp_err(errs));
      wait_wait();
    end
    check("err_sat", err_cnt, exp_err(errs));

    // Drop enable in WAIT, then reset during ARM
    deliver(8'h5A);
    wait_wait();
    check("hold_valid", m_valid, 1);
    enable = 1'b0;
    tick();
    check("dis_ce", rx_ce, 0);
    check("dis_rst_n", rx_rst_n, 1);
    enable = 1'b1;
    tick();
    check("arm_again", rx_rst_n, 0);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    check("mid_rst_rst_n", rx_rst_n, 1);
    check("mid_rst_ce", rx_ce, 0);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_full", fifo_full, 0);
    check("mid_rst_err", err_cnt, 0);

    // Enable dropped during ARM: ARM completes, one WAIT cycle, then IDLE
    rst = 1'b1;
    tick();
    check("rel_arm", rx_rst_n, 0);
    enable = 1'b0;
    count_arm(n, ce_seen);
    check("late_dis_len", n, RST_CYC);
    check("late_dis_wait", rx_ce, 1);
    tick();
    check("late_dis_idle", rx_ce, 0);
    check("late_dis_rst_n", rx_rst_n, 1);

    // Simultaneous push and pop with two bytes queued
    enable = 1'b1;
    tick();
    wait_wait();
    deliver(8'h11);
    wait_wait();
    deliver(8'h22);
    wait_wait();
    rx_data = 8'h33; rx_rdc = 1'b1;
    tick();
    m_ready = 1'b1;
    check("sp_head", m_data, 8'h11);
    tick();
    rx_rdc = 1'b0;
    m_ready = 1'b0;
    $display("[TB] byte 33 pushed while 11 popped");
    check("sp_valid", m_valid, 1);
    check("sp_full", fifo_full, 0);
    check("sp_next", m_data, 8'h22);
    m_ready = 1'b1;
    tick();
    check("sp_last", m_data, 8'h33);
    tick();
    m_ready = 1'b0;
    check("sp_empty", m_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
